// File: rtl/ysyx_24090013_wb_regfile_if.sv
// EX -> WB result handshake: EX drives the result and valid, WB answers with ready.
interface ysyx_24090013_wb_regfile_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_reg_rd_data;
  logic [4:0]  ex_reg_rd_addr;
  logic        ex_reg_rd_wen;

  modport master (
    output ex_valid, ex_reg_rd_data, ex_reg_rd_addr, ex_reg_rd_wen,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_reg_rd_data, ex_reg_rd_addr, ex_reg_rd_wen,
    output ex_ready
  );
endinterface

// File: rtl/ysyx_24090013_wb_regfile.sv
// Write-back stage: one-entry WB register, 32x32 register file (x0 = 0), two ID read
// ports and a commit trace. Define YSYX_24090013_WB_BYPASS_EN to forward the pending entry.
module ysyx_24090013_wb_regfile (
  input  logic                            clk,
  input  logic                            rst_n,
  ysyx_24090013_wb_regfile_if.slave       ex,
  input  logic                            wb_stall,
  input  logic [4:0]                      id_rs1_addr,
  input  logic [4:0]                      id_rs2_addr,
  output logic [31:0]                     id_rs1_data,
  output logic [31:0]                     id_rs2_data,
  output logic                            wb_commit_valid,
  output logic [4:0]                      wb_commit_addr,
  output logic [31:0]                     wb_commit_data,
  output logic [31:0]                     wb_retire_cnt
);

  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_addr;
  logic        r_wb_wen;
  logic [31:0] r_regs [32];
  logic [31:0] r_retire_cnt;

  logic        w_commit;
  logic        w_capture;
  logic        w_ready;

  assign w_ready   = !r_wb_valid || !wb_stall;
  assign w_commit  = r_wb_valid && !wb_stall;
  assign w_capture = ex.ex_valid && w_ready;

  assign ex.ex_ready      = w_ready;
  assign wb_commit_valid  = w_commit;
  assign wb_commit_addr   = (w_commit && r_wb_wen) ? r_wb_addr : '0;
  assign wb_commit_data   = w_commit ? r_wb_data : '0;
  assign wb_retire_cnt    = r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_addr    <= '0;
      r_wb_wen     <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      // A same-edge capture overwrites the committing entry and keeps valid set.
      if (w_capture) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= ex.ex_reg_rd_data;
        r_wb_addr  <= ex.ex_reg_rd_addr;
        r_wb_wen   <= ex.ex_reg_rd_wen;
      end else if (w_commit) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && r_wb_wen && (r_wb_addr != 5'd0)) begin
      r_regs[r_wb_addr] <= r_wb_data;
    end
  end

  always_comb begin
    id_rs1_data = '0;
    id_rs2_data = '0;
    if (id_rs1_addr != 5'd0) begin
      id_rs1_data = r_regs[id_rs1_addr];
`ifdef YSYX_24090013_WB_BYPASS_EN
      if (r_wb_valid && r_wb_wen && (r_wb_addr == id_rs1_addr)) begin
        id_rs1_data = r_wb_data;
      end
`endif
    end
    if (id_rs2_addr != 5'd0) begin
      id_rs2_data = r_regs[id_rs2_addr];
`ifdef YSYX_24090013_WB_BYPASS_EN
      if (r_wb_valid && r_wb_wen && (r_wb_addr == id_rs2_addr)) begin
        id_rs2_data = r_wb_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24090013_wb_regfile.sv
// Directed and random bench for the write-back stage against an array-based reference.
module tb_ysyx_24090013_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_stall;
  logic [4:0]  rs1a, rs2a;
  logic [31:0] rs1d, rs2d;
  logic        cv;
  logic [4:0]  ca;
  logic [31:0] cd, rc;

  always #5 clk = ~clk;

  ysyx_24090013_wb_regfile_if ex_bus ();

  ysyx_24090013_wb_regfile dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex              (ex_bus),
    .wb_stall        (wb_stall),
    .id_rs1_addr     (rs1a),
    .id_rs2_addr     (rs2a),
    .id_rs1_data     (rs1d),
    .id_rs2_data     (rs2d),
    .wb_commit_valid (cv),
    .wb_commit_addr  (ca),
    .wb_commit_data  (cd),
    .wb_retire_cnt   (rc)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [31:0] m_pdata;
  logic [4:0]  m_paddr;
  logic        m_pwen;
  logic [31:0] m_cnt;
  logic        m_last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef YSYX_24090013_WB_BYPASS_EN
    if (m_pv && m_pwen && m_paddr == a) return m_pdata;
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pv = 1'b0; m_pdata = 32'd0; m_paddr = 5'd0; m_pwen = 1'b0;
    m_cnt = 32'd0; m_last_acc = 1'b0;
  endtask

  task automatic check_outputs();
    logic commit;
    commit = m_pv && !wb_stall;
    chk("ex_ready", 32'(ex_bus.ex_ready), 32'(!m_pv || !wb_stall));
    chk("commit_valid", 32'(cv), 32'(commit));
    chk("commit_addr", 32'(ca), (commit && m_pwen) ? 32'(m_paddr) : 32'd0);
    chk("commit_data", cd, commit ? m_pdata : 32'd0);
    chk("retire_cnt", rc, m_cnt);
    chk("rs1_data", rs1d, m_read(rs1a));
    chk("rs2_data", rs2d, m_read(rs2a));
  endtask

  task automatic model_edge();
    logic commit, acc;
    commit = m_pv && !wb_stall;
    acc    = ex_bus.ex_valid && (!m_pv || !wb_stall);
    if (commit) begin
      if (m_pwen && m_paddr != 5'd0) m_regs[m_paddr] = m_pdata;
      m_cnt = m_cnt + 32'd1;
    end
    if (acc) begin
      m_pv = 1'b1;
      m_pdata = ex_bus.ex_reg_rd_data;
      m_paddr = ex_bus.ex_reg_rd_addr;
      m_pwen  = ex_bus.ex_reg_rd_wen;
    end else if (commit) begin
      m_pv = 1'b0;
    end
    m_last_acc = acc;
  endtask

  // Inputs change at posedge+1; outputs are checked at posedge+2.
  task automatic tick();
    #1;
    check_outputs();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] d, input logic [4:0] a, input logic w);
    ex_bus.ex_valid = v;
    ex_bus.ex_reg_rd_data = d;
    ex_bus.ex_reg_rd_addr = a;
    ex_bus.ex_reg_rd_wen = w;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_stall = 1'b0;
    rs1a = 5'd0; rs2a = 5'd0;
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1;

    // Reset then read
    rs1a = 5'd5;
    tick();
    chk("reset_x5", rs1d, 32'd0);
    chk("reset_ready", 32'(ex_bus.ex_ready), 32'd1);

    // Basic write-back
    offer(1'b1, 32'h12345678, 5'd3, 1'b1);
    rs1a = 5'd3;
    tick();
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    chk("basic_cv", 32'(cv), 32'd1);
    chk("basic_ca", 32'(ca), 32'd3);
    tick();
    chk("basic_x3", rs1d, 32'h12345678);
    chk("basic_cnt", rc, 32'd1);
    tick();

    // x0 write
    offer(1'b1, 32'hDEADBEEF, 5'd0, 1'b1);
    rs1a = 5'd0;
    tick();
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    #1;
    chk("x0_cv", 32'(cv), 32'd1);
    chk("x0_ca", 32'(ca), 32'd0);
    tick();
    chk("x0_read", rs1d, 32'd0);
    chk("x0_cnt", rc, 32'd2);

    // Back-to-back under stall; B offered during the last stalled cycle
    offer(1'b1, 32'h11, 5'd1, 1'b1);
    rs1a = 5'd1; rs2a = 5'd2;
    tick();
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    wb_stall = 1'b1;
    tick();
    chk("stall_ready", 32'(ex_bus.ex_ready), 32'd0);
    tick();
    offer(1'b1, 32'h22, 5'd2, 1'b1);
    tick();
    chk("stall_cv", 32'(cv), 32'd0);
    wb_stall = 1'b0;
    tick();
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    tick();
    tick();
    chk("b2b_x1", rs1d, 32'h11);
    chk("b2b_x2", rs2d, 32'h22);
    chk("b2b_cnt", rc, 32'd4);

    // Bypass of a pending entry
    offer(1'b1, 32'hAAAA0000, 5'd4, 1'b1);
    rs1a = 5'd4;
    tick();
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    wb_stall = 1'b1;
    #1;
`ifdef YSYX_24090013_WB_BYPASS_EN
    chk("bypass_rs1", rs1d, 32'hAAAA0000);
`else
    chk("nobypass_rs1", rs1d, 32'd0);
`endif
    tick();
    wb_stall = 1'b0;
    tick();
    tick();
    chk("bypass_after", rs1d, 32'hAAAA0000);

    // Reset mid-flight
    offer(1'b1, 32'h77, 5'd7, 1'b1);
    rs1a = 5'd7;
    tick();
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cv", 32'(cv), 32'd0);
    chk("rst_ready", 32'(ex_bus.ex_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("rst_x7", rs1d, 32'd0);
    chk("rst_cnt", rc, 32'd0);

    // Random traffic; an offer not accepted is held unchanged
    for (int i = 0; i < 400; i++) begin
      wb_stall = ($urandom_range(0, 3) == 0);
      if (!(ex_bus.ex_valid && !m_last_acc)) begin
        offer(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 4) != 0));
      end
      rs1a = 5'($urandom_range(0, 31));
      rs2a = ($urandom_range(0, 3) == 0) ? m_paddr : 5'($urandom_range(0, 31));
      tick();
    end
    offer(1'b0, 32'd0, 5'd0, 1'b0);
    wb_stall = 1'b0;
    tick();
    for (int r = 0; r < 32; r++) begin
      rs1a = 5'(r);
      rs2a = 5'(31 - r);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
